instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/riscv_pkg.sv | 65 ++++++
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared state encoding, opcode constants and decode helper for instr_sequencer
package riscv_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int unsigned WD_LIMIT = 16;
  localparam int unsigned WD_W     = 4;

  typedef struct packed {
    logic legal;
    logic system;
    logic load;
    logic store;
    logic no_rd;
  } op_class_t;

  // Stores and branches have no destination register, so they never write back.
  function automatic op_class_t classify(input logic [6:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_REG, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: c.legal = 1'b1;
      OP_LOAD: begin
        c.legal = 1'b1;
        c.load  = 1'b1;
      end
      OP_STORE: begin
        c.legal = 1'b1;
        c.store = 1'b1;
        c.no_rd = 1'b1;
      end
      OP_BRANCH: begin
        c.legal = 1'b1;
        c.no_rd = 1'b1;
      end
      OP_SYSTEM: begin
        c.legal  = 1'b1;
        c.system = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle instruction sequencer FSM; INSTR_SEQ_RETIRE_COUNT_EN enables retired_count
module instr_sequencer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step_en,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic        ir_load_en,
  output logic        reg_write_en,
  output logic        pc_write_en,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] retired_count
);

  state_t          cur;
  logic [WD_W-1:0] wd;
  logic            is_load;
  logic            is_store;
  logic            rd_write;
  op_class_t       dec;
  logic            wd_expire;
  logic            unused_instr;

  assign state        = cur;
  assign dec          = classify(instruction[6:0]);
  assign wd_expire    = (wd == WD_W'(WD_LIMIT - 1));
  assign unused_instr = ^instruction[31:12];

  // Level strobes follow the state they belong to; pulse strobes clear every clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur          <= S_IDLE;
      wd           <= '0;
      trap         <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      ir_load_en   <= 1'b0;
      reg_write_en <= 1'b0;
      pc_write_en  <= 1'b0;
      is_load      <= 1'b0;
      is_store     <= 1'b0;
      rd_write     <= 1'b0;
    end else begin
      ir_load_en   <= 1'b0;
      reg_write_en <= 1'b0;
      pc_write_en  <= 1'b0;
      if (step_en) begin
        case (cur)
          S_IDLE: begin
            if (!halt_req) begin
              cur         <= S_FETCH;
              mem_read_en <= 1'b1;
            end
          end
          S_FETCH: begin
            if (mem_ready) begin
              cur         <= S_DECODE;
              mem_read_en <= 1'b0;
              ir_load_en  <= 1'b1;
              wd          <= '0;
            end else if (wd_expire) begin
              cur         <= S_TRAP;
              trap        <= 1'b1;
              mem_read_en <= 1'b0;
              wd          <= '0;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_DECODE: begin
            is_load  <= dec.load;
            is_store <= dec.store;
            rd_write <= !dec.no_rd && (instruction[11:7] != 5'd0);
            if (!dec.legal) begin
              cur  <= S_TRAP;
              trap <= 1'b1;
            end else if (dec.system) begin
              cur <= S_HALT;
            end else begin
              cur <= S_EXECUTE;
            end
          end
          S_EXECUTE: begin
            if (is_load || is_store) begin
              cur          <= S_MEMORY;
              mem_read_en  <= is_load;
              mem_write_en <= is_store;
            end else begin
              cur <= S_WRITEBACK;
            end
          end
          S_MEMORY: begin
            if (mem_ready) begin
              cur          <= S_WRITEBACK;
              mem_read_en  <= 1'b0;
              mem_write_en <= 1'b0;
              wd           <= '0;
            end else if (wd_expire) begin
              cur          <= S_TRAP;
              trap         <= 1'b1;
              mem_read_en  <= 1'b0;
              mem_write_en <= 1'b0;
              wd           <= '0;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_WRITEBACK: begin
            pc_write_en  <= 1'b1;
            reg_write_en <= rd_write;
            if (halt_req) begin
              cur <= S_HALT;
            end else begin
              cur         <= S_FETCH;
              mem_read_en <= 1'b1;
            end
          end
          S_HALT: begin
            if (!halt_req) begin
              cur         <= S_FETCH;
              mem_read_en <= 1'b1;
            end
          end
          S_TRAP: begin
            trap <= 1'b1;
          end
          default: begin
            cur  <= S_TRAP;
            trap <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef INSTR_SEQ_RETIRE_COUNT_EN
  logic [31:0] retired_cnt;
  logic        retire;

  assign retire        = step_en && (cur == S_WRITEBACK);
  assign retired_count = retired_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer against a behavioural model
module tb_instr_sequencer;

`ifdef INSTR_SEQ_RETIRE_COUNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] SW   = 32'h0011_2023;
  localparam logic [31:0] LW   = 32'h0000_2083;
  localparam logic [31:0] BAD  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_en = 1'b0;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_read_en, mem_write_en, ir_load_en, reg_write_en, pc_write_en;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  instr_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .step_en      (step_en),
    .instruction  (instruction),
    .mem_ready    (mem_ready),
    .halt_req     (halt_req),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .ir_load_en   (ir_load_en),
    .reg_write_en (reg_write_en),
    .pc_write_en  (pc_write_en),
    .state        (state),
    .trap         (trap),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Reference model: state numbers, stall tick count, and the class of the decoded instruction.
  logic [6:0]  legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
  int          m_state = 0;
  int          m_stalls = 0;
  bit          m_trap = 0, m_ld = 0, m_st = 0, m_wr = 0;
  bit          m_ir = 0, m_pc = 0, m_rw = 0;
  logic [31:0] m_ret = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 10; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit s, input bit r, input bit h, input bit rs);
    int nxt;
    logic [6:0] op;
    m_ir = 0; m_pc = 0; m_rw = 0;
    if (rs) begin
      m_state = 0; m_stalls = 0; m_trap = 0; m_ret = '0;
    end else if (s) begin
      nxt = m_state;
      if (m_state == 0 || m_state == 6) begin
        if (!h) nxt = 1;
      end else if (m_state == 1 || m_state == 4) begin
        if (r) begin
          nxt = (m_state == 1) ? 2 : 5;
          m_ir = (m_state == 1);
        end else begin
          m_stalls++;
          if (m_stalls >= 16) nxt = 7;
        end
      end else if (m_state == 2) begin
        op = instruction[6:0];
        m_ld = (op == 7'h03);
        m_st = (op == 7'h23);
        m_wr = !(m_st || op == 7'h63) && instruction[11:7] != 5'd0;
        nxt = (op == 7'h73) ? 6 : (is_legal(op) ? 3 : 7);
      end else if (m_state == 3) begin
        nxt = (m_ld || m_st) ? 4 : 5;
      end else if (m_state == 5) begin
        m_pc = 1; m_rw = m_wr; m_ret = m_ret + 32'd1;
        nxt = h ? 6 : 1;
      end
      if (nxt != m_state) m_stalls = 0;
      if (nxt == 7) m_trap = 1;
      m_state = nxt;
    end
  endtask

  task automatic check_all();
    logic [4:0] exp_strb;
    exp_strb = {m_state == 1 || (m_state == 4 && m_ld), m_state == 4 && m_st, m_ir, m_rw, m_pc};
    check("state", 32'(state), 32'(m_state));
    check("trap", 32'(trap), 32'(m_trap));
    check("strobes", 32'({mem_read_en, mem_write_en, ir_load_en, reg_write_en, pc_write_en}), 32'(exp_strb));
    check("retired", retired_count, RC_EN ? m_ret : 32'd0);
  endtask

  task automatic tick(input bit s, input bit r, input bit h, input bit rs);
    step_en = s; mem_ready = r; halt_req = h; reset = rs;
    @(posedge clk);
    model_step(s, r, h, rs);
    #1;
    check_all();
  endtask

  initial begin
    int rw_cnt, mw_cnt, pc_cnt;
    int seq [5] = '{1, 2, 3, 5, 1};

    tick(1, 1, 0, 1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'({mem_read_en, mem_write_en, ir_load_en, reg_write_en, pc_write_en, trap}), 32'd0);

    instruction = ADDI;
    rw_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 0, 0);
      check("addi_seq", 32'(state), 32'(seq[i]));
      rw_cnt += int'(reg_write_en);
    end
    check("addi_rw", 32'(rw_cnt), 32'd1);
    check("addi_ret", retired_count, RC_EN ? 32'd1 : 32'd0);

    instruction = SW;
    mw_cnt = 0; rw_cnt = 0; pc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1, !(i >= 3 && i <= 5), 0, 0);
      mw_cnt += int'(mem_write_en); rw_cnt += int'(reg_write_en); pc_cnt += int'(pc_write_en);
    end
    check("sw_mw", 32'(mw_cnt), 32'd4);
    check("sw_rw", 32'(rw_cnt), 32'd0);
    check("sw_pc", 32'(pc_cnt), 32'd1);
    check("sw_state", 32'(state), 32'd1);

    instruction = BAD;
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    check("bad_trap", 32'(trap), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      check("bad_hold", 32'(state), 32'd7);
    end
    tick(1, 1, 0, 1);
    check("bad_reset", 32'({state, trap}), 32'd0);

    tick(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick(1, 0, 0, 0);
    check("wd_15", 32'(state), 32'd1);
    tick(1, 0, 0, 0);
    check("wd_16", 32'(state), 32'd7);

    tick(1, 1, 0, 1);
    instruction = ADDI;
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    check("halt_state", 32'(state), 32'd6);
    check("halt_pc", 32'(pc_write_en), 32'd1);
    tick(1, 1, 1, 0);
    check("halt_hold", 32'(state), 32'd6);
    tick(1, 1, 0, 0);
    check("halt_exit", 32'(state), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      check("idle_step", 32'({state, mem_read_en}), 32'({3'd1, 1'b1}));
    end

    instruction = LW;
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    check("lw_mem", 32'({state, mem_read_en}), 32'({3'd4, 1'b1}));
    tick(1, 1, 0, 1);
    check("lw_reset", 32'({state, mem_read_en, mem_write_en, ir_load_en, reg_write_en, pc_write_en, trap}), 32'd0);

`ifdef INSTR_SEQ_RETIRE_COUNT_EN
    dut.retired_cnt = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    instruction = ADDI;
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    check("wrap", retired_count, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if (m_state == 1) begin
        instruction = {$urandom_range(0, 32'h1FFFF), 5'($urandom_range(0, 31)), 7'($urandom_range(0, 127))};
        if ($urandom_range(0, 9) != 0) instruction[6:0] = legal_ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 5) == 0) instruction[11:7] = 5'd0;
      end
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
